// File: rtl/tt_ctrl_seq_pkg.sv
// Shared types and defaults for the tt_ctrl_seq mux-control sequencer.
// Holds the state enum, the default timing constants and the timer width helper.
package tt_ctrl_seq_pkg;

    localparam int DEF_ADDR_W    = 10;
    localparam int DEF_PULSE_CYC = 4;
    localparam int DEF_GAP_CYC   = 4;
    localparam int DEF_RST_CYC   = 8;

    typedef enum logic [2:0] {
        IDLE,
        DIS,
        RST,
        INC_HI,
        INC_LO,
        ENA
    } state_t;

    // One shared down-counter covers every interval, so size it for the longest.
    function automatic int timer_width(input int pulse_cyc, input int gap_cyc, input int rst_cyc);
        int m;
        m = pulse_cyc;
        if (gap_cyc > m) m = gap_cyc;
        if (rst_cyc > m) m = rst_cyc;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/tt_ctrl_seq_timer.sv
// Loadable down-counter with zero flag; times the RST, INC_HI and INC_LO intervals.
module tt_ctrl_seq_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop regardless of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/tt_ctrl_seq.sv
// Mux-control sequencer: turns a requested design address into the reset/increment/enable
// pulse train on the mux control pins. Optional relative stepping: TT_CTRL_SEQ_RELATIVE_EN.
module tt_ctrl_seq
    import tt_ctrl_seq_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int GAP_CYC   = DEF_GAP_CYC,
    parameter int RST_CYC   = DEF_RST_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_ena,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              cur_valid,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena
);

    localparam int TMR_W = timer_width(PULSE_CYC, GAP_CYC, RST_CYC);
    localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYC - 1);
    localparam logic [TMR_W-1:0] RST_LD   = TMR_W'(RST_CYC - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   target_q, target_d;
    logic                ena_q, ena_d;
    logic                skip_q, skip_d;
    logic                tmr_load, tmr_dec, tmr_zero;
    logic [TMR_W-1:0]    tmr_val;

    logic                req_ready_d, busy_d, done_d, cur_valid_d;
    logic                sel_rst_n_d, sel_inc_d, ctrl_ena_d;
    logic [ADDR_W-1:0]   cur_addr_d;

    tt_ctrl_seq_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Outputs are registered from the next-state view so each pin changes with its state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            target_q       <= '0;
            ena_q          <= 1'b0;
            skip_q         <= 1'b0;
            req_ready      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            cur_addr       <= '0;
            cur_valid      <= 1'b0;
            ctrl_sel_rst_n <= 1'b1;
            ctrl_sel_inc   <= 1'b0;
            ctrl_ena       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            target_q       <= target_d;
            ena_q          <= ena_d;
            skip_q         <= skip_d;
            req_ready      <= req_ready_d;
            busy           <= busy_d;
            done           <= done_d;
            cur_addr       <= cur_addr_d;
            cur_valid      <= cur_valid_d;
            ctrl_sel_rst_n <= sel_rst_n_d;
            ctrl_sel_inc   <= sel_inc_d;
            ctrl_ena       <= ctrl_ena_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        ena_d    = ena_q;
        skip_d   = skip_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = '0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    target_d = req_addr;
                    ena_d    = req_ena;
                    state_d  = DIS;
`ifdef TT_CTRL_SEQ_RELATIVE_EN
                    // Step forward from a known selection instead of resetting the mux.
                    if (cur_valid && (req_addr >= cur_addr)) begin
                        skip_d = 1'b1;
                        cnt_d  = req_addr - cur_addr;
                    end else begin
                        skip_d = 1'b0;
                        cnt_d  = req_addr;
                    end
`else
                    skip_d = 1'b0;
                    cnt_d  = req_addr;
`endif
                end
            end
            DIS: begin
                if (!skip_q) begin
                    state_d  = RST;
                    tmr_load = 1'b1;
                    tmr_val  = RST_LD;
                end else if (cnt_q == '0) begin
                    state_d = ENA;
                end else begin
                    state_d  = INC_HI;
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LD;
                end
            end
            RST, INC_LO: begin
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = ENA;
                end else begin
                    state_d  = INC_HI;
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LD;
                end
            end
            INC_HI: begin
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else begin
                    state_d  = INC_LO;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LD;
                    cnt_d    = cnt_q - ADDR_W'(1);
                end
            end
            ENA:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == ENA);
        sel_rst_n_d = (state_d != RST);
        sel_inc_d   = (state_d == INC_HI);
        ctrl_ena_d  = ctrl_ena;
        cur_addr_d  = cur_addr;
        cur_valid_d = cur_valid;
        case (state_d)
            DIS: begin
                ctrl_ena_d  = 1'b0;
                cur_valid_d = 1'b0;
            end
            ENA: begin
                ctrl_ena_d  = ena_q;
                cur_addr_d  = target_q;
                cur_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/tt_ctrl_seq.md
Name: tt_ctrl_seq

Overview:
Parametrised mux-control sequencer. It converts a requested design address into the pulse train on the mux control pins: ctrl_sel_rst_n, ctrl_sel_inc and ctrl_ena. It sits between an address source (EEPROM autoselect, debug host) and the pad outputs driving the mux controller. Generalises the fixed-width, fixed-timing selection logic with configurable address width and pulse timing, request handshake, completion reporting and an optional relative-stepping mode.

Parameters:
ADDR_W, 10, width of design address and increment counter
PULSE_CYC, 4, cycles ctrl_sel_inc held high per increment (>=1)
GAP_CYC, 4, cycles ctrl_sel_inc held low after each pulse (>=1)
RST_CYC, 8, cycles ctrl_sel_rst_n held low (>=1)

Ports:
clk  input  1  single clock
rst_n  input  1  synchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept request
req_addr  input  ADDR_W  target design address
req_ena  input  1  value ctrl_ena takes after selection
busy  output  1  sequence in progress (state != IDLE)
done  output  1  one-cycle pulse at sequence completion
cur_addr  output  ADDR_W  address currently selected
cur_valid  output  1  cur_addr is trustworthy
ctrl_sel_rst_n  output  1  mux select counter reset, active low
ctrl_sel_inc  output  1  mux select counter increment
ctrl_ena  output  1  mux enable

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n.
- All outputs are registered.
- Reset values: req_ready=0, busy=0, done=0, cur_addr=0, cur_valid=0, ctrl_sel_rst_n=1, ctrl_sel_inc=0, ctrl_ena=0.
- req_ready=1 in every IDLE cycle after reset, including the first cycle after rst_n rises.
- States: IDLE, DIS, RST, INC_HI, INC_LO, ENA.
- IDLE: req_ready=1. Handshake (req_valid & req_ready) at cycle T latches req_addr and req_ena, then moves to DIS. No other state accepts a request.
- DIS (cycle T+1): ctrl_ena=0, cur_valid=0.
- DIS exit: go to RST, or go to INC_HI/ENA when RST is skipped (see optional feature).
- RST: ctrl_sel_rst_n=0 for exactly RST_CYC cycles. Remaining increment count is loaded with the target.
- RST exit: if count==0 go to ENA, else go to INC_HI.
- INC_HI: ctrl_sel_inc=1 for PULSE_CYC cycles.
- INC_LO: ctrl_sel_inc=0 for GAP_CYC cycles; the count decrements once per pulse.
- INC_LO exit: if count==0 go to ENA, else go to INC_HI.
- ENA (one cycle): ctrl_ena=req_ena, done=1, cur_addr=target, cur_valid=1. Next state is IDLE.
- Latency, full path, N=target: done at T+2+RST_CYC+N*(PULSE_CYC+GAP_CYC).
- Target 0: no increment pulses.
- Target 2^ADDR_W-1: full-width count with no overflow; the counter is ADDR_W bits.
- req_valid while busy: ignored (req_ready=0). The requester holds the request; it is accepted in the next IDLE cycle.
- rst_n low in any state: return to IDLE with reset values on the next edge. cur_valid=0 because the mux state is unknown.
- Timers share one down-counter of width clog2(max(PULSE_CYC,GAP_CYC,RST_CYC))+1.

Optional Feature:
TT_CTRL_SEQ_RELATIVE_EN.
- Defined, with cur_valid=1 at acceptance:
  - target > cur_addr: skip RST, issue target-cur_addr increments.
  - target == cur_addr: DIS then ENA, no pulses.
  - target < cur_addr: full reset path.
- Defined, with cur_valid=0 at acceptance: full reset path.
- Undefined: every request takes the full reset path; cur_addr/cur_valid are still maintained.

Decomposition:
- Package tt_ctrl_seq_pkg holds:
  - state enum (IDLE, DIS, RST, INC_HI, INC_LO, ENA);
  - default timing constants;
  - a function computing timer width.
- One sub-module, tt_ctrl_seq_timer: loadable down-counter with zero flag, reused for RST, HI and LO intervals.

Test Plan:
Defaults throughout: ADDR_W=10, PULSE_CYC=4, GAP_CYC=4, RST_CYC=8.
- Reset with outputs observed: ctrl_sel_rst_n=1, ctrl_sel_inc=0, ctrl_ena=0, cur_valid=0; req_ready=1 first cycle after rst_n rises.
- req_addr=0, req_ena=1 accepted at T -> ctrl_sel_rst_n low T+2..T+9, no inc pulses, done and ctrl_ena=1 at T+10, cur_addr=0.
- req_addr=3, req_ena=1 -> three 4-high/4-low inc pulses, done at T+34, cur_addr=3.
- req_addr=1023 -> exactly 1023 pulses, done at T+10+8184.
- req_valid held during busy -> req_ready=0 throughout; request accepted in the IDLE cycle after done; ctrl_ena drops in its DIS cycle.
- rst_n low mid-INC_HI (pulse 2 of 3) -> next cycle IDLE, outputs at reset values, cur_valid=0.
- With TT_CTRL_SEQ_RELATIVE_EN, from cur_addr=3:
  - target 5: no RST, 2 pulses, done at T+18.
  - target 3: done at T+2.
  - target 2: full reset path.
- Same sequence with the macro undefined -> all three take the full reset path.
